ofmap_rd_ctrl: RTL and testbench
================================

Name: ofmap_rd_ctrl

Overview:
- Read-side controller for the output feature-map buffer that the neuron write path fills.
- After a layer finishes, it walks the buffer plane by plane (PLANE_SIZE words per plane, planes at stride PLANE_SIZE) and issues BRAM reads.
- It absorbs the fixed BRAM read latency and streams words downstream over a valid/ready interface, with plane-last and frame-last markers.
- It sits between the ofmap BRAM read port and the next-layer or pooling input.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory and stream word width.
- PLANE_SIZE, 196, words per output plane (R*C); also the plane base-address stride.
- NUM_PLANES, 6, number of planes per frame.
- RD_LAT, 2, BRAM read latency in cycles, fixed; must be 1..3.
- FIFO_DEPTH, 4, output skid FIFO depth; must be >= RD_LAT+1 and a power of 2.

Ports:
- clk, input, 1, single clock, all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse; begins a frame read; ignored unless idle.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse after the last word is accepted downstream.
- mem_rd_en, output, 1, read strobe to BRAM.
- mem_rd_addr, output, ADDR_W, read address.
- mem_rd_data, input, DATA_W, BRAM data, valid RD_LAT cycles after mem_rd_en.
- out_valid, output, 1, stream word valid.
- out_ready, input, 1, downstream accept.
- out_data, output, DATA_W, stream word.
- out_plane_last, output, 1, qualifies the last word of each plane.
- out_last, output, 1, qualifies the last word of the frame.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (rst sampled on posedge clk).
  - Outputs in reset: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_plane_last=0, out_last=0.
  - Internal state cleared: FIFO emptied, in-flight count=0, word and plane counters=0, state=IDLE.
- rst asserted mid-frame aborts the frame immediately: no done pulse, FIFO contents discarded.
- States:
  - IDLE: on start go to ISSUE.
  - ISSUE: issue reads. Move to DRAIN after the read of word PLANE_SIZE-1 of plane NUM_PLANES-1 is issued.
  - DRAIN: wait until in-flight=0 and FIFO empty with the last word accepted, then go to FIN.
  - FIN: pulse done for 1 cycle, return to IDLE.
- Issue rule (credit): mem_rd_en=1 in ISSUE only when fifo_count + inflight < FIFO_DEPTH, evaluated with current-cycle pops counted. The FIFO therefore never overflows; an overflow is an assertion failure.
- Address generation:
  - mem_rd_addr = plane_idx*PLANE_SIZE + word_idx, computed incrementally with no multiplier: the address increments by 1 per issued read.
  - word_idx wraps at PLANE_SIZE-1, and plane_idx then increments.
  - Arithmetic is modulo 2^ADDR_W.
- Return path: a shift-register tag pipeline of depth RD_LAT carries {valid, plane_last, last}. When a tag exits the pipeline, the FIFO pushes {mem_rd_data, tags}.
- Stream:
  - out_valid = FIFO not empty; out_data and the last markers come from the FIFO head.
  - Pop when out_valid && out_ready.
  - Once out_valid is asserted, out_data and markers must stay stable until accepted.
- Latency: first out_valid appears RD_LAT+2 cycles after start (1 cycle start→ISSUE, RD_LAT BRAM, 1 cycle FIFO register).
- Throughput: with out_ready held high, 1 word per cycle sustained.
- Ordering: output order is strictly address order; exactly NUM_PLANES*PLANE_SIZE words per frame.
- start while busy: ignored; it does not restart or queue.
- Simultaneous FIFO push and pop when full is legal; count is unchanged.

Optional Feature:
- Macro: OFMAP_RD_CHKSUM_EN.
- Defined:
  - Adds output port chksum (32 bits): the running modulo-2^32 sum of all accepted out_data (zero-extended).
  - chksum clears on accepted start and on rst, and is held after done until the next start.
- Undefined: no port and no logic are present; all other behaviour is identical.

Test Plan:
- rst high 3 cycles, then out_ready=1, start pulse, PLANE_SIZE=4, NUM_PLANES=2, memory[a]=a+100:
  - out_data is 100..107 on consecutive cycles.
  - out_plane_last is high on 103 and 107; out_last is high on 107 only.
  - done pulses once, 1-2 cycles after 107 is accepted.
- Default params, out_ready=1:
  - First out_valid 4 cycles after start.
  - 1176 words, no gaps; mem_rd_addr runs 0..1175; plane 1 starts at addr 196.
- Backpressure: out_ready toggling 1/0 every cycle, then held 0 for 20 cycles:
  - out_data is stable while stalled.
  - mem_rd_en stops once FIFO_DEPTH credits are used; no word is lost or duplicated; full sequence is intact.
- Second start pulsed during busy:
  - It is ignored; exactly one done per frame.
  - A new start after done replays the frame from addr 0.
- rst asserted after 50 words of frame:
  - Next cycle all outputs are at reset values, no done pulse.
  - A subsequent start reads from addr 0.
- With OFMAP_RD_CHKSUM_EN and memory[a]=a+100, PLANE_SIZE=4, NUM_PLANES=2: chksum=828 after done.

Source files
------------

// File: rtl/ofmap_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_rd_ctrl
// Brief    : Output feature-map read controller. It walks the ofmap BRAM plane
//            by plane and hides the fixed BRAM read latency behind a credit-
//            managed skid FIFO. Words are streamed out over valid/ready with
//            plane-last and frame-last markers.
// Options  : OFMAP_RD_CHKSUM_EN adds a 32-bit running checksum output (chksum)
//            covering the accepted stream words.
// Revision : 1.0 - initial release
// ============================================================================
module ofmap_rd_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int PLANE_SIZE = 196,
    parameter int NUM_PLANES = 6,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_plane_last,
    output logic              out_last
`ifdef OFMAP_RD_CHKSUM_EN
    ,
    output logic [31:0]       chksum
`endif
);

    localparam int WORD_W  = (PLANE_SIZE > 1) ? $clog2(PLANE_SIZE) : 1;
    localparam int PLANE_W = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W   = DATA_W + 2;

    localparam logic [WORD_W-1:0]  WORD_MAX  = WORD_W'(PLANE_SIZE - 1);
    localparam logic [PLANE_W-1:0] PLANE_MAX = PLANE_W'(NUM_PLANES - 1);
    localparam logic [CNT_W:0]     DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   word_q;
    logic [PLANE_W-1:0]  plane_q;
    logic [RD_LAT-1:0]   tag_v_q, tag_pl_q, tag_last_q;
    logic [CNT_W-1:0]    inflight_q;
    logic [ENT_W-1:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    fifo_cnt_q;

    logic                issue, push, pop, start_acc;
    logic                is_plast, is_last;
    logic [CNT_W:0]      credit_used;
    logic [ENT_W-1:0]    head;

    assign start_acc = (state_q == S_IDLE) && start;
    assign pop       = (fifo_cnt_q != '0) && out_ready;
    assign push      = tag_v_q[RD_LAT-1];
    assign is_plast  = (word_q == WORD_MAX);
    assign is_last   = is_plast && (plane_q == PLANE_MAX);
    // Slots already spoken for: FIFO words plus reads still in the BRAM,
    // minus the word leaving the FIFO this cycle.
    assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight_q}
                       - {{CNT_W{1'b0}}, pop};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state, read issue and status strobes.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: begin
                if (credit_used < DEPTH_C) begin
                    issue = 1'b1;
                    if (is_last) state_d = S_DRAIN;
                end
            end
            // Nothing in flight means no further push; leave once the FIFO is
            // empty or its final word is being accepted right now.
            S_DRAIN: begin
                if ((inflight_q == '0) &&
                    ((fifo_cnt_q == '0) ||
                     ((fifo_cnt_q == CNT_W'(1)) && pop)))
                    state_d = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign mem_rd_en   = issue;
    assign mem_rd_addr = addr_q;

    // Address walk: linear address plus word/plane position for the markers.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            addr_q  <= '0;
            word_q  <= '0;
            plane_q <= '0;
        end else if (issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (is_plast) begin
                word_q  <= '0;
                plane_q <= (plane_q == PLANE_MAX) ? '0 : plane_q + PLANE_W'(1);
            end else begin
                word_q <= word_q + WORD_W'(1);
            end
        end
    end

    // Tag pipeline that tracks each read through the BRAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q    <= '0;
            tag_pl_q   <= '0;
            tag_last_q <= '0;
            inflight_q <= '0;
        end else begin
            tag_v_q[0]    <= issue;
            tag_pl_q[0]   <= is_plast;
            tag_last_q[0] <= is_last;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i]    <= tag_v_q[i-1];
                tag_pl_q[i]   <= tag_pl_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
            inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(push);
        end
    end

    // Skid FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Skid FIFO storage; contents are don't-care while the slot is unused.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_q[wr_ptr_q] <= {mem_rd_data, tag_pl_q[RD_LAT-1],
                                     tag_last_q[RD_LAT-1]};
    end

    assign head           = fifo_mem_q[rd_ptr_q];
    assign out_valid      = (fifo_cnt_q != '0);
    assign out_data       = head[ENT_W-1:2];
    assign out_plane_last = out_valid & head[1];
    assign out_last       = out_valid & head[0];

    // The credit rule must keep the FIFO from ever overflowing.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !pop) |-> (fifo_cnt_q < CNT_W'(FIFO_DEPTH)));

`ifdef OFMAP_RD_CHKSUM_EN
    logic [31:0] chksum_q;

    // Running sum of accepted words, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_acc) chksum_q <= '0;
        else if (pop)         chksum_q <= chksum_q + 32'(out_data);
    end

    assign chksum = chksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofmap_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofmap_rd_ctrl
// Brief    : Self-checking bench for ofmap_rd_ctrl with a behavioural BRAM and
//            a queue-based model of the expected output stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofmap_rd_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int PS     = 196;
    localparam int NP     = 6;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;
    localparam int TOTAL  = PS * NP;

    logic              clk = 1'b0;
    logic              rst, start, busy, done, mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data, out_data;
    logic              out_valid, out_ready, out_plane_last, out_last;
`ifdef OFMAP_RD_CHKSUM_EN
    logic [31:0]       chksum;
`endif

    ofmap_rd_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PLANE_SIZE(PS), .NUM_PLANES(NP),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .out_plane_last(out_plane_last), .out_last(out_last)
`ifdef OFMAP_RD_CHKSUM_EN
        , .chksum(chksum)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Behavioural BRAM: word at address a is a*mk+moff (mod 2^DATA_W).
    int unsigned mk = 1, moff = 100;
    function automatic logic [DATA_W-1:0] memf(input int unsigned a);
        return DATA_W'(a * mk + moff);
    endfunction

    logic [DATA_W-1:0] dp [RD_LAT];
    always @(posedge clk) begin
        dp[0] <= mem_rd_en ? memf(int'(mem_rd_addr)) : DATA_W'($urandom);
        for (int i = 1; i < RD_LAT; i++) dp[i] <= dp[i-1];
    end
    assign mem_rd_data = dp[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected stream model.
    logic [DATA_W+1:0] exp_q [$];
    logic [DATA_W+1:0] mon_e;
    int                issue_addr, outstanding, accepted;
    int                last_acc_cyc, first_valid_cyc, frames_done, start_cyc;
    bit                frame_active;
    logic [31:0]       msum;
    logic [DATA_W-1:0] got_d    [TOTAL];
    bit                got_pl   [TOTAL];
    bit                got_last [TOTAL];

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                check("rd_addr", 64'(mem_rd_addr), 64'(issue_addr % 65536));
                check("rd_in_frame", 64'(frame_active && issue_addr < TOTAL), 1);
                issue_addr++;
                outstanding++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    mon_e = exp_q[0];
                    check("out_data", 64'(out_data), 64'(mon_e[DATA_W+1:2]));
                    check("out_plane_last", 64'(out_plane_last), 64'(mon_e[1]));
                    check("out_last", 64'(out_last), 64'(mon_e[0]));
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (accepted < TOTAL) begin
                            got_d[accepted]    = out_data;
                            got_pl[accepted]   = out_plane_last;
                            got_last[accepted] = out_last;
                        end
                        accepted++;
                        msum = msum + 32'(out_data);
                        outstanding--;
                        last_acc_cyc = cyc;
                    end
                end
            end
            if (mem_rd_en || out_valid)
                check("credit_limit", 64'(outstanding <= DEPTH), 1);
            if (done) begin
                check("done_pulse", 64'(frame_active && accepted == TOTAL &&
                      (cyc - last_acc_cyc) >= 1 && (cyc - last_acc_cyc) <= 2), 1);
                frame_active = 1'b0;
                frames_done++;
            end
        end
    end

    task automatic chk_reset_outs();
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_mem_rd_en", 64'(mem_rd_en), 0);
        check("rst_mem_rd_addr", 64'(mem_rd_addr), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_plane_last", 64'(out_plane_last), 0);
        check("rst_out_last", 64'(out_last), 0);
    endtask

    task automatic start_frame(input int unsigned k, input int unsigned off);
        @(posedge clk); #1;
        mk = k;
        moff = off;
        exp_q.delete();
        for (int a = 0; a < TOTAL; a++)
            exp_q.push_back({memf(a), (a % PS) == PS - 1, a == TOTAL - 1});
        issue_addr = 0;
        outstanding = 0;
        accepted = 0;
        first_valid_cyc = -1;
        msum = 0;
        frame_active = 1'b1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(busy), 1);
    endtask

    // mode 0: ready held high; mode 1: ready random (75% high).
    task automatic wait_done(input int budget, input int mode);
        int f0 = frames_done;
        int n = 0;
        while (frames_done == f0 && n < budget) begin
            @(posedge clk); #1;
            out_ready = (mode == 0) ? 1'b1 : (($urandom % 4) != 0);
            n++;
        end
        if (frames_done == f0) check("done_timeout", 0, 1);
        @(negedge clk);
        check("idle_busy", 64'(busy), 0);
        check("single_done", 64'(done), 0);
        check("frame_words", 64'(accepted), 64'(TOTAL));
        check("queue_empty", 64'(exp_q.size()), 0);
`ifdef OFMAP_RD_CHKSUM_EN
        check("chksum", 64'(chksum), 64'(msum));
`endif
    endtask

    task automatic literal_frame_checks();
        int npl = 0;
        check("first_valid_latency", 64'(first_valid_cyc - start_cyc), 4);
        check("no_gaps", 64'(last_acc_cyc - first_valid_cyc), 64'(TOTAL - 1));
        check("word0", 64'(got_d[0]), 100);
        check("word195", 64'(got_d[195]), 295);
        check("word195_pl", 64'(got_pl[195]), 1);
        check("word196", 64'(got_d[196]), 296);
        check("word196_pl", 64'(got_pl[196]), 0);
        check("word1175", 64'(got_d[TOTAL-1]), 1275);
        check("word1175_last", 64'(got_last[TOTAL-1]), 1);
        check("word1174_last", 64'(got_last[TOTAL-2]), 0);
        for (int i = 0; i < TOTAL; i++) npl += int'(got_pl[i]);
        check("plane_last_count", 64'(npl), 64'(NP));
`ifdef OFMAP_RD_CHKSUM_EN
        check("chksum_literal", 64'(chksum), 808500);
`endif
    endtask

    initial begin
        int fd0, n;
        logic [DATA_W-1:0] held;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        frame_active = 1'b0;
        frames_done = 0;
        issue_addr = 0;
        outstanding = 0;
        accepted = 0;
        msum = 0;
        first_valid_cyc = -1;
        last_acc_cyc = 0;
        start_cyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame A: ready high, address-plus-100 memory.
        out_ready = 1'b1;
        start_frame(1, 100);
        wait_done(3000, 0);
        literal_frame_checks();

        // Frame B: toggling ready, long stall, ignored second start.
        fd0 = frames_done;
        start_frame($urandom, $urandom);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            out_ready = i[0];
            start = (i == 60);
        end
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("stall_valid", 64'(out_valid), 1);
        check("stall_data", 64'(out_data), 64'(held));
        check("stall_rd_en", 64'(mem_rd_en), 0);
        check("stall_credits_used", 64'(outstanding), 64'(DEPTH));
        wait_done(10000, 1);
        repeat (10) @(posedge clk);
        check("one_done_per_frame", 64'(frames_done - fd0), 1);

        // Frame C: fresh start after done replays from address 0.
        start_frame($urandom, $urandom);
        wait_done(10000, 1);

        // Frame D: reset after 50 accepted words aborts the frame.
        fd0 = frames_done;
        out_ready = 1'b1;
        start_frame($urandom, $urandom);
        n = 0;
        while (accepted < 50 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reached_50", 64'(accepted >= 50), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        frame_active = 1'b0;
        exp_q.delete();
        issue_addr = 0;
        outstanding = 0;
        @(negedge clk);
        chk_reset_outs();
`ifdef OFMAP_RD_CHKSUM_EN
        check("abort_chksum", 64'(chksum), 0);
`endif
        repeat (10) @(posedge clk);
        check("abort_no_done", 64'(frames_done - fd0), 0);

        // Frame E: start after abort reads from address 0 again.
        out_ready = 1'b1;
        start_frame(1, 100);
        wait_done(3000, 0);
        literal_frame_checks();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
